// File: rtl/mdio_pkg.sv
// Shared constants for the CSR-controlled MDIO master: FSM encodings,
// register indices, frame field constants and the frame builder.
package mdio_pkg;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_PREAMBLE = 3'd1;
  localparam logic [2:0] S_HDR      = 3'd2;
  localparam logic [2:0] S_TA       = 3'd3;
  localparam logic [2:0] S_DATA     = 3'd4;
  localparam logic [2:0] S_DONE     = 3'd5;

  localparam logic [1:0] REG_CMD    = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_RDATA  = 2'd2;

  localparam logic [1:0] MDIO_ST       = 2'b01;
  localparam logic [1:0] MDIO_OP_READ  = 2'b10;
  localparam logic [1:0] MDIO_OP_WRITE = 2'b01;
  localparam logic [1:0] MDIO_TA_WRITE = 2'b10;

  // Index of the last bit of each frame section (bit counter value).
  localparam logic [5:0] BIT_PRE_LAST = 6'd31;
  localparam logic [5:0] BIT_HDR_LAST = 6'd45;
  localparam logic [5:0] BIT_TA_LAST  = 6'd47;
  localparam logic [5:0] BIT_LAST     = 6'd63;

  // Reads fill TA/DATA with ones so the idle-high level is kept while oe is low.
  function automatic logic [63:0] build_frame(input logic        op_read,
                                              input logic [4:0]  phyad,
                                              input logic [4:0]  regad,
                                              input logic [15:0] wdata);
    logic [1:0]  op;
    logic [1:0]  ta;
    logic [15:0] data;
    op   = op_read ? MDIO_OP_READ : MDIO_OP_WRITE;
    ta   = op_read ? 2'b11 : MDIO_TA_WRITE;
    data = op_read ? 16'hFFFF : wdata;
    return {32'hFFFF_FFFF, MDIO_ST, op, phyad, regad, ta, data};
  endfunction

endpackage

// File: rtl/mdio_clkgen.sv
// MDC divider: low half then high half per bit time, with one-cycle strobes
// that are active on the cycle before MDC changes level.
module mdio_clkgen #(
  parameter int CLK_DIV = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic mdc,
  output logic fall_stb,
  output logic rise_stb
);

  logic [7:0] cnt_q, cnt_d;
  logic       mdc_q, mdc_d;
  logic       half_end;

  always_comb begin
    half_end = en && (cnt_q == 8'(CLK_DIV - 1));
    rise_stb = half_end && !mdc_q;
    fall_stb = half_end && mdc_q;
    cnt_d    = cnt_q;
    mdc_d    = mdc_q;
    if (!en) begin
      cnt_d = 8'd0;
      mdc_d = 1'b0;
    end else if (half_end) begin
      cnt_d = 8'd0;
      mdc_d = !mdc_q;
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 8'd0;
      mdc_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      mdc_q <= mdc_d;
    end
  end

  assign mdc = mdc_q;

endmodule

// File: rtl/csr_mdio.sv
// CSR-programmed MDIO (clause 22) master: one 64-bit-time frame per CMD write,
// STATUS with sticky done/rejected, RDATA holding the last read result.
module csr_mdio
  import mdio_pkg::*;
#(
  parameter logic [3:0] csr_addr = 4'h9,
  parameter int         CLK_DIV  = 10
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [13:0] csr_a,
  input  logic        csr_we,
  input  logic [31:0] csr_di,
  output logic [31:0] csr_do,
  output logic        irq,
  output logic        phy_mdc,
  output logic        phy_mdio_o,
  output logic        phy_mdio_oe,
  input  logic        phy_mdio_i
);

  logic [2:0]  state_q, state_d;
  logic [5:0]  bit_cnt_q, bit_cnt_d;
  logic [63:0] frame_q, frame_d;
  logic        mdio_o_q, mdio_o_d;
  logic        oe_q, oe_d;
  logic [26:0] cmd_q, cmd_d;
  logic [15:0] rdata_q, rdata_d;
  logic [15:0] rd_shift_q, rd_shift_d;
  logic        done_q, done_d;
  logic        rej_q, rej_d;
  logic [31:0] csr_do_q, csr_do_d;

  logic bank_sel, cmd_wr, sts_wr, busy, running;
  logic fall_stb, rise_stb;
  logic unused_ok;

  assign bank_sel  = (csr_a[13:10] == csr_addr);
  assign cmd_wr    = csr_we && bank_sel && (csr_a[1:0] == REG_CMD);
  assign sts_wr    = csr_we && bank_sel && (csr_a[1:0] == REG_STATUS);
  assign busy      = (state_q != S_IDLE);
  assign running   = busy && (state_q != S_DONE);
  assign unused_ok = ^{csr_a[9:2], csr_di[31:27]};

  mdio_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
    .clk      (sys_clk),
    .rst      (sys_rst),
    .en       (running),
    .mdc      (phy_mdc),
    .fall_stb (fall_stb),
    .rise_stb (rise_stb)
  );

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    frame_d    = frame_q;
    mdio_o_d   = mdio_o_q;
    oe_d       = oe_q;
    cmd_d      = cmd_q;
    rdata_d    = rdata_q;
    rd_shift_d = rd_shift_q;
    done_d     = done_q;
    rej_d      = rej_q;

    // Clears come first so a same-cycle set below takes priority.
    if (sts_wr) begin
      if (csr_di[1]) done_d = 1'b0;
      if (csr_di[2]) rej_d  = 1'b0;
    end
    if (cmd_wr && busy) rej_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        mdio_o_d = 1'b1;
        oe_d     = 1'b0;
        if (cmd_wr) begin
          cmd_d     = csr_di[26:0];
          frame_d   = build_frame(csr_di[26], csr_di[25:21], csr_di[20:16], csr_di[15:0]);
          mdio_o_d  = frame_d[63];
          oe_d      = 1'b1;
          bit_cnt_d = 6'd0;
          state_d   = S_PREAMBLE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        if (cmd_q[26]) rdata_d = rd_shift_q;
      end
      default: begin
        if (rise_stb && (state_q == S_DATA)) rd_shift_d = {rd_shift_q[14:0], phy_mdio_i};
        // Each MDC fall starts the next bit; the fall after bit 63 ends the frame.
        if (fall_stb) begin
          if (bit_cnt_q == BIT_LAST) begin
            state_d  = S_DONE;
            mdio_o_d = 1'b1;
            oe_d     = 1'b0;
          end else begin
            bit_cnt_d = bit_cnt_q + 6'd1;
            frame_d   = {frame_q[62:0], 1'b1};
            mdio_o_d  = frame_q[62];
            if (bit_cnt_q == BIT_PRE_LAST) begin
              state_d = S_HDR;
            end else if (bit_cnt_q == BIT_HDR_LAST) begin
              state_d = S_TA;
              if (cmd_q[26]) oe_d = 1'b0;
            end else if (bit_cnt_q == BIT_TA_LAST) begin
              state_d = S_DATA;
            end
          end
        end
      end
    endcase

    csr_do_d = 32'd0;
    if (bank_sel) begin
      case (csr_a[1:0])
        REG_CMD:    csr_do_d = {5'd0, cmd_q};
        REG_STATUS: csr_do_d = {29'd0, rej_q, done_q, busy};
        REG_RDATA:  csr_do_d = {16'd0, rdata_q};
        default:    csr_do_d = 32'd0;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= 6'd0;
      frame_q    <= 64'd0;
      mdio_o_q   <= 1'b1;
      oe_q       <= 1'b0;
      cmd_q      <= 27'd0;
      rdata_q    <= 16'd0;
      rd_shift_q <= 16'd0;
      done_q     <= 1'b0;
      rej_q      <= 1'b0;
      csr_do_q   <= 32'd0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      frame_q    <= frame_d;
      mdio_o_q   <= mdio_o_d;
      oe_q       <= oe_d;
      cmd_q      <= cmd_d;
      rdata_q    <= rdata_d;
      rd_shift_q <= rd_shift_d;
      done_q     <= done_d;
      rej_q      <= rej_d;
      csr_do_q   <= csr_do_d;
    end
  end

  assign csr_do      = csr_do_q;
  assign irq         = (state_q == S_DONE);
  assign phy_mdio_o  = mdio_o_q;
  assign phy_mdio_oe = oe_q;

endmodule

// File: tb/tb_csr_mdio.sv
// Directed bench for csr_mdio: frame capture on MDC, a PHY read-data model,
// CSR driver tasks and one task per scenario.
`timescale 1ns/1ps
module tb_csr_mdio;

  localparam int          CLK_DIV = 10;
  localparam logic [3:0]  BANK    = 4'h9;
  localparam logic [13:0] A_CMD   = {BANK, 8'h00, 2'd0};
  localparam logic [13:0] A_STS   = {BANK, 8'h00, 2'd1};
  localparam logic [13:0] A_RDATA = {BANK, 8'h00, 2'd2};
  localparam logic [13:0] A_REG3  = {BANK, 8'h00, 2'd3};
  localparam logic [13:0] A_STS_X = {4'h3, 8'h00, 2'd1};
  localparam logic [13:0] A_CMD_X = {4'h3, 8'h00, 2'd0};

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic [13:0] csr_a   = '0;
  logic        csr_we  = 1'b0;
  logic [31:0] csr_di  = '0;
  logic [31:0] csr_do;
  logic        irq, phy_mdc, phy_mdio_o, phy_mdio_oe;
  logic        phy_mdio_i = 1'b1;

  csr_mdio #(.csr_addr(BANK), .CLK_DIV(CLK_DIV)) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .csr_a       (csr_a),
    .csr_we      (csr_we),
    .csr_di      (csr_di),
    .csr_do      (csr_do),
    .irq         (irq),
    .phy_mdc     (phy_mdc),
    .phy_mdio_o  (phy_mdio_o),
    .phy_mdio_oe (phy_mdio_oe),
    .phy_mdio_i  (phy_mdio_i)
  );

  // clock / reset
  always #5 sys_clk = ~sys_clk;

  int total = 0;
  int bad   = 0;
  logic [63:0] exp_q[$];

  // Monitors: frame/oe capture on MDC rise, PHY read data on MDC fall.
  logic [63:0] cap_frame = '0;
  logic [63:0] cap_oe    = '0;
  int          mdc_rise  = 0;
  int          mdc_fall  = 0;
  int          fall_base = 0;
  int          irq_seen  = 0;
  int          edge_viol = 0;
  logic [15:0] phy_data  = '0;
  logic        prev_o    = 1'b1;
  logic        prev_mdc  = 1'b0;
  logic        prev_rst  = 1'b1;

  always @(posedge phy_mdc) begin
    cap_frame = {cap_frame[62:0], phy_mdio_o};
    cap_oe    = {cap_oe[62:0], phy_mdio_oe};
    mdc_rise++;
  end

  always @(negedge phy_mdc) begin
    int k;
    mdc_fall++;
    k = 63 - (mdc_fall - fall_base);
    if (k >= 0 && k <= 15) phy_mdio_i = phy_data[k[3:0]];
    else                   phy_mdio_i = 1'b1;
  end

  always @(posedge sys_clk) if (irq === 1'b1) irq_seen++;

  always @(negedge sys_clk) begin
    if (!sys_rst && !prev_rst && (phy_mdio_o !== prev_o) && !(prev_mdc === 1'b1 && phy_mdc === 1'b0))
      edge_viol++;
    prev_o   = phy_mdio_o;
    prev_mdc = phy_mdc;
    prev_rst = sys_rst;
  end

  // driver tasks
  task automatic csr_write(input logic [13:0] a, input logic [31:0] d);
    @(negedge sys_clk);
    csr_a  = a;
    csr_di = d;
    csr_we = 1'b1;
    @(negedge sys_clk);
    csr_we = 1'b0;
    csr_di = '0;
  endtask

  task automatic csr_read(input logic [13:0] a, output logic [31:0] d);
    @(negedge sys_clk);
    csr_a  = a;
    csr_we = 1'b0;
    @(negedge sys_clk);
    d = csr_do;
  endtask

  task automatic wait_irq(output int cycles);
    cycles = 0;
    while (irq !== 1'b1 && cycles < 3000) begin
      @(negedge sys_clk);
      cycles++;
    end
  endtask

  task automatic start_frame_counters(output int rise_base, output int irq_base, output int viol_base);
    rise_base = mdc_rise;
    irq_base  = irq_seen;
    viol_base = edge_viol;
    fall_base = mdc_fall;
  endtask

  // scenarios
  task automatic test_reset();
    logic [31:0] d;
    sys_rst = 1'b1;
    repeat (3) @(negedge sys_clk);
    total++; if (phy_mdc !== 1'b0) begin bad++; $display("FAIL rst_mdc: got %b want 0", phy_mdc); end
    total++; if (phy_mdio_o !== 1'b1) begin bad++; $display("FAIL rst_mdio_o: got %b want 1", phy_mdio_o); end
    total++; if (phy_mdio_oe !== 1'b0) begin bad++; $display("FAIL rst_oe: got %b want 0", phy_mdio_oe); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL rst_irq: got %b want 0", irq); end
    total++; if (csr_do !== 32'd0) begin bad++; $display("FAIL rst_csr_do: got %h want 0", csr_do); end
    sys_rst = 1'b0;
    csr_read(A_STS, d);
    total++; if (d !== 32'd0) begin bad++; $display("FAIL rst_status: got %h want 0", d); end
    csr_read(A_CMD, d);
    total++; if (d !== 32'd0) begin bad++; $display("FAIL rst_cmd: got %h want 0", d); end
    csr_read(A_RDATA, d);
    total++; if (d !== 32'd0) begin bad++; $display("FAIL rst_rdata: got %h want 0", d); end
  endtask

  task automatic test_write_frame();
    int rb, ib, vb, cyc;
    logic [31:0] d;
    logic [63:0] exp_frame;
    start_frame_counters(rb, ib, vb);
    // phy=2 reg=1 write 0x1234: 0101 00010 00001 10 = 0x5106
    exp_q.push_back(64'hFFFF_FFFF_5106_1234);
    csr_write(A_CMD, 32'h0041_1234);
    total++; if (phy_mdio_oe !== 1'b1) begin bad++; $display("FAIL wr_oe_start: got %b want 1", phy_mdio_oe); end
    wait_irq(cyc);
    total++; if (cyc !== 1280) begin bad++; $display("FAIL wr_irq_latency: got %0d want 1280", cyc); end
    @(negedge sys_clk);
    exp_frame = exp_q.pop_front();
    total++; if (mdc_rise - rb !== 64) begin bad++; $display("FAIL wr_mdc_pulses: got %0d want 64", mdc_rise - rb); end
    total++; if (cap_frame !== exp_frame) begin bad++; $display("FAIL wr_frame: got %h want %h", cap_frame, exp_frame); end
    total++; if (cap_oe !== 64'hFFFF_FFFF_FFFF_FFFF) begin bad++; $display("FAIL wr_oe: got %h want all ones", cap_oe); end
    total++; if (irq_seen - ib !== 1) begin bad++; $display("FAIL wr_irq_count: got %0d want 1", irq_seen - ib); end
    total++; if (edge_viol - vb !== 0) begin bad++; $display("FAIL wr_mdio_edge: got %0d changes off MDC fall want 0", edge_viol - vb); end
    total++; if (phy_mdio_oe !== 1'b0 || phy_mdio_o !== 1'b1) begin bad++; $display("FAIL wr_idle_after: got oe=%b o=%b want oe=0 o=1", phy_mdio_oe, phy_mdio_o); end
    csr_read(A_STS, d);
    total++; if (d !== 32'h2) begin bad++; $display("FAIL wr_status: got %h want 2", d); end
    csr_read(A_CMD, d);
    total++; if (d !== 32'h0041_1234) begin bad++; $display("FAIL wr_cmd_readback: got %h want 00411234", d); end
  endtask

  task automatic test_read_frame();
    int rb, ib, vb, cyc;
    logic [31:0] d;
    csr_write(A_STS, 32'h6);
    phy_data = 16'hBEEF;
    start_frame_counters(rb, ib, vb);
    // phy=1 reg=2 read: 01 10 00001 00010 = 14'h1822
    csr_write(A_CMD, 32'h0422_0000);
    wait_irq(cyc);
    total++; if (cyc !== 1280) begin bad++; $display("FAIL rd_irq_latency: got %0d want 1280", cyc); end
    @(negedge sys_clk);
    total++; if (mdc_rise - rb !== 64) begin bad++; $display("FAIL rd_mdc_pulses: got %0d want 64", mdc_rise - rb); end
    total++; if (cap_oe !== 64'hFFFF_FFFF_FFFC_0000) begin bad++; $display("FAIL rd_oe: got %h want fffffffffffc0000", cap_oe); end
    total++; if (cap_frame[63:18] !== {32'hFFFF_FFFF, 14'h1822}) begin bad++; $display("FAIL rd_header: got %h want %h", cap_frame[63:18], {32'hFFFF_FFFF, 14'h1822}); end
    total++; if (edge_viol - vb !== 0) begin bad++; $display("FAIL rd_mdio_edge: got %0d want 0", edge_viol - vb); end
    csr_read(A_RDATA, d);
    total++; if (d !== 32'h0000_BEEF) begin bad++; $display("FAIL rd_rdata: got %h want 0000beef", d); end
    csr_read(A_STS, d);
    total++; if (d !== 32'h2) begin bad++; $display("FAIL rd_status: got %h want 2", d); end
  endtask

  task automatic test_back_to_back();
    int rb, ib, vb, cyc;
    logic [31:0] d;
    logic [63:0] exp_frame;
    csr_write(A_STS, 32'h6);
    start_frame_counters(rb, ib, vb);
    // phy=3 reg=4 write 0xa5c3: 0101 00011 00100 10 = 0x5192
    exp_q.push_back(64'hFFFF_FFFF_5192_A5C3);
    csr_write(A_CMD, 32'h0064_A5C3);
    repeat (4) @(negedge sys_clk);
    csr_write(A_CMD, 32'h0422_0000);
    csr_read(A_STS, d);
    total++; if (d !== 32'h5) begin bad++; $display("FAIL b2b_status_busy: got %h want 5", d); end
    csr_read(A_CMD, d);
    total++; if (d !== 32'h0064_A5C3) begin bad++; $display("FAIL b2b_cmd_kept: got %h want 0064a5c3", d); end
    wait_irq(cyc);
    total++; if (cyc >= 3000) begin bad++; $display("FAIL b2b_irq_timeout: got %0d cycles want irq", cyc); end
    @(negedge sys_clk);
    exp_frame = exp_q.pop_front();
    total++; if (cap_frame !== exp_frame) begin bad++; $display("FAIL b2b_frame: got %h want %h", cap_frame, exp_frame); end
    total++; if (mdc_rise - rb !== 64) begin bad++; $display("FAIL b2b_mdc_pulses: got %0d want 64", mdc_rise - rb); end
    csr_read(A_STS, d);
    total++; if (d !== 32'h6) begin bad++; $display("FAIL b2b_status_after: got %h want 6", d); end
  endtask

  task automatic test_reset_midframe();
    int rb, ib, vb, cyc, n;
    logic [31:0] d;
    logic [63:0] exp_frame;
    csr_write(A_STS, 32'h6);
    phy_data = 16'h1357;
    start_frame_counters(rb, ib, vb);
    csr_write(A_CMD, 32'h0422_0000);
    n = 0;
    while (mdc_rise - rb < 41 && n < 2000) begin
      @(negedge sys_clk);
      n++;
    end
    total++; if (mdc_rise - rb !== 41) begin bad++; $display("FAIL mid_reach_bit40: got %0d rises want 41", mdc_rise - rb); end
    sys_rst = 1'b1;
    @(negedge sys_clk);
    total++; if (phy_mdc !== 1'b0 || phy_mdio_oe !== 1'b0 || phy_mdio_o !== 1'b1) begin
      bad++; $display("FAIL mid_abort_pins: got mdc=%b oe=%b o=%b want 0 0 1", phy_mdc, phy_mdio_oe, phy_mdio_o);
    end
    sys_rst = 1'b0;
    repeat (100) @(negedge sys_clk);
    total++; if (irq_seen - ib !== 0) begin bad++; $display("FAIL mid_no_irq: got %0d want 0", irq_seen - ib); end
    csr_read(A_RDATA, d);
    total++; if (d !== 32'd0) begin bad++; $display("FAIL mid_rdata: got %h want 0", d); end
    csr_read(A_STS, d);
    total++; if (d !== 32'd0) begin bad++; $display("FAIL mid_status: got %h want 0", d); end
    start_frame_counters(rb, ib, vb);
    exp_q.push_back(64'hFFFF_FFFF_5106_1234);
    csr_write(A_CMD, 32'h0041_1234);
    wait_irq(cyc);
    total++; if (cyc !== 1280) begin bad++; $display("FAIL mid_new_latency: got %0d want 1280", cyc); end
    @(negedge sys_clk);
    exp_frame = exp_q.pop_front();
    total++; if (cap_frame !== exp_frame) begin bad++; $display("FAIL mid_new_frame: got %h want %h", cap_frame, exp_frame); end
    total++; if (mdc_rise - rb !== 64) begin bad++; $display("FAIL mid_new_pulses: got %0d want 64", mdc_rise - rb); end
  endtask

  task automatic test_done_clear_race();
    int cyc;
    logic [31:0] d;
    csr_write(A_STS, 32'h6);
    csr_write(A_CMD, 32'h0041_1234);
    wait_irq(cyc);
    total++; if (cyc !== 1280) begin bad++; $display("FAIL race_latency: got %0d want 1280", cyc); end
    // Clear write lands on the same edge that leaves DONE.
    csr_a  = A_STS;
    csr_di = 32'h2;
    csr_we = 1'b1;
    @(negedge sys_clk);
    csr_we = 1'b0;
    csr_di = '0;
    csr_read(A_STS, d);
    total++; if (d !== 32'h2) begin bad++; $display("FAIL race_done_kept: got %h want 2", d); end
    csr_write(A_STS, 32'h2);
    csr_read(A_STS, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL race_done_cleared: got %h want 0", d); end
  endtask

  task automatic test_bank_select();
    logic [31:0] d;
    csr_write(A_CMD_X, 32'h0064_A5C3);
    total++; if (phy_mdio_oe !== 1'b0) begin bad++; $display("FAIL bank_no_start: got oe=%b want 0", phy_mdio_oe); end
    csr_read(A_CMD, d);
    total++; if (d !== 32'h0041_1234) begin bad++; $display("FAIL bank_cmd_unchanged: got %h want 00411234", d); end
    csr_write(A_CMD, 32'h0422_0000);
    csr_read(A_STS_X, d);
    total++; if (d !== 32'd0) begin bad++; $display("FAIL bank_unsel_status: got %h want 0", d); end
    csr_a = A_STS;
    #1;
    total++; if (csr_do !== 32'd0) begin bad++; $display("FAIL bank_latency_early: got %h want 0", csr_do); end
    @(negedge sys_clk);
    total++; if (csr_do !== 32'h1) begin bad++; $display("FAIL bank_sel_status: got %h want 1", csr_do); end
    csr_read(A_REG3, d);
    total++; if (d !== 32'd0) begin bad++; $display("FAIL bank_reg3: got %h want 0", d); end
    csr_read(A_CMD_X, d);
    total++; if (d !== 32'd0) begin bad++; $display("FAIL bank_unsel_cmd: got %h want 0", d); end
  endtask

  initial begin
    test_reset();
    test_write_frame();
    test_read_frame();
    test_back_to_back();
    test_reset_midframe();
    test_done_clear_race();
    test_bank_select();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
